// File: rtl/viterbi_ber_ctrl.sv
// BER test sequencer: drives the convolutional encoder, injects channel errors and counts
// decoded/channel bit errors per frame. Define VITERBI_BURST_ERR_EN to repeat each injected mask once.
module viterbi_ber_ctrl #(
    parameter int          FRAME_LEN = 256,
    parameter int          TAIL_LEN  = 2,
    parameter int          DEC_LAT   = 40,
    parameter logic [15:0] DATA_SEED = 16'hACE1,
    parameter logic [15:0] ERR_SEED  = 16'h1D0F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [3:0]  err_rate_i,
    input  logic        decoder_o_i,
    output logic        encoder_i,
    output logic        enable_encoder_i,
    output logic [1:0]  err_mask_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] bit_err_ct_o,
    output logic [15:0] chan_err_ct_o
);
    typedef enum logic [2:0] {IDLE, RUN, TAIL, DRAIN, DONE} state_t;

    localparam logic [15:0] RUN_LAST  = 16'(FRAME_LEN - 1);
    localparam logic [15:0] TAIL_LAST = 16'((TAIL_LEN > 0) ? TAIL_LEN - 1 : 0);
    // Every stage except the last; the last one is compared in the current cycle.
    localparam logic [DEC_LAT-1:0] EARLY_MASK = {DEC_LAT{1'b1}} >> 1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    state_t               state, state_nx;
    logic [15:0]          cnt;
    logic [15:0]          data_lfsr;
    logic [15:0]          err_lfsr;
    logic [15:0]          bit_err_ct;
    logic [15:0]          chan_err_ct;
    logic [DEC_LAT-1:0]   vld_p;
    logic [DEC_LAT-1:0]   bit_p;
    logic                 active;
    logic                 inject;
    logic                 cmp_err;
    logic [1:0]           lfsr_mask;
    logic [1:0]           mask_pop;
`ifdef VITERBI_BURST_ERR_EN
    logic                 rpt;
    logic [1:0]           rpt_mask;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_i) state_nx = RUN;
            RUN:     if (cnt == RUN_LAST) state_nx = (TAIL_LEN > 0) ? TAIL : DRAIN;
            TAIL:    if (cnt == TAIL_LAST) state_nx = DRAIN;
            DRAIN:   if ((vld_p & EARLY_MASK) == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort_i && state != IDLE) state_nx = IDLE;
    end

    always_comb begin
        active     = (state == RUN) || (state == TAIL);
        inject     = active && (err_lfsr[3:0] < err_rate_i);
        lfsr_mask  = {err_lfsr[15], ~err_lfsr[15]};
        err_mask_o = inject ? lfsr_mask : 2'b00;
`ifdef VITERBI_BURST_ERR_EN
        if (active && rpt) err_mask_o = rpt_mask;
`endif
        mask_pop         = {1'b0, err_mask_o[1]} + {1'b0, err_mask_o[0]};
        encoder_i        = (state == RUN) && data_lfsr[0];
        enable_encoder_i = active;
        busy_o           = (state != IDLE);
        done_o           = (state == DONE);
        cmp_err          = vld_p[DEC_LAT-1] && (decoder_o_i != bit_p[DEC_LAT-1]);
    end

    assign bit_err_ct_o  = bit_err_ct;
    assign chan_err_ct_o = chan_err_ct;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            data_lfsr   <= DATA_SEED;
            err_lfsr    <= ERR_SEED;
            bit_err_ct  <= '0;
            chan_err_ct <= '0;
            vld_p       <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx != state) ? 16'd0 : cnt + 16'd1;
            if (state == IDLE && start_i) begin
                data_lfsr   <= DATA_SEED;
                err_lfsr    <= ERR_SEED;
                bit_err_ct  <= '0;
                chan_err_ct <= '0;
            end else begin
                if (state == RUN) data_lfsr <= lfsr_next(data_lfsr);
                if (active) err_lfsr <= lfsr_next(err_lfsr);
                chan_err_ct <= sat_add(chan_err_ct, mask_pop);
                if (cmp_err) bit_err_ct <= sat_add(bit_err_ct, 2'd1);
            end
            // p0 captures the payload bit; p[DEC_LAT-1] lines up with decoder_o_i
            if (abort_i && state != IDLE) vld_p <= '0;
            else vld_p <= (vld_p << 1) | DEC_LAT'(state == RUN);
        end
    end

    always_ff @(posedge clk) begin
        bit_p <= (bit_p << 1) | DEC_LAT'(encoder_i);
    end

`ifdef VITERBI_BURST_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst) rpt <= 1'b0;
        else      rpt <= inject && !rpt;
        rpt_mask <= lfsr_mask;
    end
`endif

endmodule

// File: tb/tb_viterbi_ber_ctrl.sv
// Self-checking bench for viterbi_ber_ctrl: directed frame table, hand-written corner
// sequences and randomized traffic against a frame-position reference model.
module tb_viterbi_ber_ctrl;
    localparam int FL = 16;
    localparam int TL = 2;
    localparam int DL = 4;
    localparam int DONE_POS = ((FL + DL > FL + TL + 1) ? FL + DL : FL + TL + 1) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [3:0]    err_rate_i = 4'd0;
    logic          flip = 1'b0;
    logic [DL-1:0] dly = '0;
    logic          decoder_o_i;
    logic          encoder_i;
    logic          enable_encoder_i;
    logic [1:0]    err_mask_o;
    logic          busy_o;
    logic          done_o;
    logic [15:0]   bit_err_ct_o;
    logic [15:0]   chan_err_ct_o;

    always #5 clk = ~clk;

    viterbi_ber_ctrl #(
        .FRAME_LEN(FL), .TAIL_LEN(TL), .DEC_LAT(DL),
        .DATA_SEED(16'hACE1), .ERR_SEED(16'h1D0F)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .err_rate_i(err_rate_i), .decoder_o_i(decoder_o_i),
        .encoder_i(encoder_i), .enable_encoder_i(enable_encoder_i),
        .err_mask_o(err_mask_o), .busy_o(busy_o), .done_o(done_o),
        .bit_err_ct_o(bit_err_ct_o), .chan_err_ct_o(chan_err_ct_o)
    );

    // Decoder stand-in: a DL-cycle delay of the encoder bit, optionally inverted.
    always @(posedge clk) dly <= {dly[DL-2:0], encoder_i};
    assign decoder_o_i = dly[DL-1] ^ flip;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    endtask

    // Reference model: pos = cycles since the accepted start (0 = idle).
    int          pos = 0;
    logic        pay [FL];
    logic [15:0] ev  [FL+TL];
    int          m_bit = 0;
    int          m_chan = 0;
`ifdef VITERBI_BURST_ERR_EN
    bit          m_rep = 1'b0;
    logic [1:0]  m_rep_mask = 2'b00;
`endif

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        int taps [4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        foreach (taps[i]) fb ^= v[16 - taps[i]];
        return {fb, v[15:1]};
    endfunction

    function automatic void gen_frame();
        logic [15:0] v = 16'hACE1;
        logic [15:0] e = 16'h1D0F;
        for (int i = 0; i < FL; i++) begin pay[i] = v[0]; v = lfsr_step(v); end
        for (int i = 0; i < FL + TL; i++) begin ev[i] = e; e = lfsr_step(e); end
    endfunction

    function automatic bit in_tx();
        return pos >= 1 && pos <= FL + TL;
    endfunction

    function automatic bit raw_inj();
        return in_tx() && (ev[pos-1][3:0] < err_rate_i);
    endfunction

    function automatic logic [1:0] exp_mask();
        if (!in_tx()) return 2'b00;
`ifdef VITERBI_BURST_ERR_EN
        if (m_rep) return m_rep_mask;
`endif
        if (raw_inj()) return {ev[pos-1][15], ~ev[pos-1][15]};
        return 2'b00;
    endfunction

    function automatic logic exp_enc();
        return (pos >= 1 && pos <= FL) ? pay[pos-1] : 1'b0;
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    always @(posedge clk) begin
        logic [1:0] mk;
        mk = exp_mask();
        if (!rst) begin
            pos = 0; m_bit = 0; m_chan = 0;
`ifdef VITERBI_BURST_ERR_EN
            m_rep = 1'b0;
`endif
        end else begin
            m_chan = sat16(m_chan + int'(mk[0]) + int'(mk[1]));
            if (pos - DL >= 1 && pos - DL <= FL && decoder_o_i !== pay[pos-DL-1])
                m_bit = sat16(m_bit + 1);
`ifdef VITERBI_BURST_ERR_EN
            m_rep_mask = mk;
            m_rep = !m_rep && raw_inj();
`endif
            if (pos == 0) begin
                if (start_i) begin gen_frame(); pos = 1; m_bit = 0; m_chan = 0; end
            end else if (abort_i || pos == DONE_POS) pos = 0;
            else pos++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("sb_busy", 16'(busy_o), 16'(pos != 0));
            check("sb_enable", 16'(enable_encoder_i), 16'(in_tx()));
            check("sb_encoder", 16'(encoder_i), 16'(exp_enc()));
            check("sb_mask", 16'(err_mask_o), 16'(exp_mask()));
            check("sb_done", 16'(done_o), 16'(pos == DONE_POS));
            check("sb_bit_err", bit_err_ct_o, 16'(m_bit));
            check("sb_chan_err", chan_err_ct_o, 16'(m_chan));
        end
    end

    function automatic int full_inj_count();
        int n = 0;
        bit rep = 1'b0;
        for (int a = 0; a < FL + TL; a++) begin
`ifdef VITERBI_BURST_ERR_EN
            if (rep) begin n++; rep = 1'b0; end
            else if (ev[a][3:0] != 4'hF) begin n++; rep = 1'b1; end
`else
            if (ev[a][3:0] != 4'hF) n++;
`endif
        end
        return n;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Runs until done_o is seen (checked 4 time units after the edge) or the budget expires.
    task automatic run_to_done(input string nm, output int dones);
        bit seen = 1'b0;
        dones = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            cyc();
            start_i = 1'b0;
            flip = (pos - DL == 6);
            #3;
            if (done_o) begin seen = 1'b1; dones++; end
        end
        if (!seen) check({nm, "_timeout"}, 16'd0, 16'd1);
        flip = 1'b0;
    endtask

    typedef struct {
        logic start;
        logic exp_busy;
        logic exp_en;
        logic exp_done;
        logic chk_enc;
        logic exp_enc;
    } vec_t;

    vec_t tbl [26];

    initial begin
        logic [3:0] first4 = 4'b0001;
        int dones;
        for (int r = 0; r < 26; r++)
            tbl[r] = '{r == 0, r >= 1 && r <= 21, r >= 1 && r <= 18, r == 21,
                       r >= 1 && r <= 4, (r >= 1 && r <= 4) ? first4[(r + 3) % 4] : 1'b0};

        cyc(); cyc();
        rst = 1'b1;
        chk_en = 1'b1;
        #3;
        check("reset_busy", 16'(busy_o), 16'd0);
        check("reset_enable", 16'(enable_encoder_i), 16'd0);
        check("reset_counts", bit_err_ct_o | chan_err_ct_o, 16'd0);

        // Clean frame, cycle by cycle from the table.
        for (int r = 0; r < 26; r++) begin
            cyc();
            start_i = tbl[r].start;
            #3;
            check($sformatf("tbl_busy_c%0d", r), 16'(busy_o), 16'(tbl[r].exp_busy));
            check($sformatf("tbl_enable_c%0d", r), 16'(enable_encoder_i), 16'(tbl[r].exp_en));
            check($sformatf("tbl_done_c%0d", r), 16'(done_o), 16'(tbl[r].exp_done));
            if (tbl[r].chk_enc)
                check($sformatf("tbl_encoder_c%0d", r), 16'(encoder_i), 16'(tbl[r].exp_enc));
        end
        check("clean_bit_err", bit_err_ct_o, 16'd0);
        check("clean_chan_err", chan_err_ct_o, 16'd0);

        // Single decoded error on payload bit 5.
        cyc(); start_i = 1'b1;
        run_to_done("single_err", dones);
        check("single_err_bit_ct", bit_err_ct_o, 16'd1);
        check("single_err_chan_ct", chan_err_ct_o, 16'd0);

        // Full injection.
        cyc(); err_rate_i = 4'd15; start_i = 1'b1;
        run_to_done("full_inj", dones);
        check("full_inj_chan_ct", chan_err_ct_o, 16'(full_inj_count()));
        check("full_inj_bit_ct", bit_err_ct_o, 16'd1);
        cyc(); err_rate_i = 4'd0;

        // Abort at the 8th RUN cycle, with a coincident start that must lose.
        cyc(); start_i = 1'b1;
        for (int i = 0; i < 40 && pos != 8; i++) begin cyc(); start_i = 1'b0; end
        abort_i = 1'b1; start_i = 1'b1;
        cyc(); abort_i = 1'b0; start_i = 1'b0;
        #3;
        check("abort_busy", 16'(busy_o), 16'd0);
        check("abort_enable", 16'(enable_encoder_i), 16'd0);
        check("abort_done", 16'(done_o), 16'd0);
        cyc(); cyc(); start_i = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            cyc(); start_i = 1'b0;
            #3;
            check($sformatf("restart_encoder_%0d", r), 16'(encoder_i), 16'(first4[r-1]));
        end
        run_to_done("restart", dones);
        check("restart_dones", 16'(dones), 16'd1);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            cyc();
            err_rate_i = 4'($urandom_range(15));
            flip = ($urandom_range(7) == 0);
            start_i = ($urandom_range(3) == 0);
            abort_i = ($urandom_range(59) == 0);
        end
        cyc(); start_i = 1'b0; abort_i = 1'b0; flip = 1'b0;
        for (int c = 0; c < 40; c++) cyc();

        // Reset in DRAIN.
        err_rate_i = 4'd15; start_i = 1'b1;
        for (int i = 0; i < 60 && pos != FL + TL + 1; i++) begin cyc(); start_i = 1'b0; end
        check("drain_reached", 16'(pos), 16'(FL + TL + 1));
        rst = 1'b0;
        cyc(); rst = 1'b1;
        #3;
        check("rst_drain_busy", 16'(busy_o), 16'd0);
        check("rst_drain_done", 16'(done_o), 16'd0);
        check("rst_drain_mask", 16'(err_mask_o), 16'd0);
        check("rst_drain_counts", bit_err_ct_o | chan_err_ct_o, 16'd0);
        dones = 0;
        for (int i = 0; i < 30; i++) begin cyc(); #3; if (done_o) dones++; end
        check("rst_drain_no_done", 16'(dones), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/viterbi_ber_ctrl.md
Name: viterbi_ber_ctrl

Overview:
- Test sequencer for the convolutional encoder → noisy channel → Viterbi decoder chain.
- Generates a pseudo-random payload frame and drives the encoder's input and enable.
- Appends trellis-flush tail bits and supplies a per-cycle 2-bit error-injection mask to the channel.
- Compares decoder output against the delayed transmitted bits and reports decoded and channel bit-error counts at end of frame.

Parameters:
- FRAME_LEN, 256, payload bits per frame (≥1, ≤65535).
- TAIL_LEN, 2, zero flush bits sent after the payload (≥0).
- DEC_LAT, 40, cycles from encoder-enable cycle of bit k to decoder_o carrying bit k (≥1).
- DATA_SEED, 16'hACE1, reload value of the payload LFSR (nonzero).
- ERR_SEED, 16'h1D0F, reload value of the error LFSR (nonzero).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-low reset
- start_i  in  1  begin a frame; sampled only in IDLE
- abort_i  in  1  terminate the current frame, return to IDLE
- err_rate_i  in  4  injection threshold; per-cycle inject probability err_rate_i/16; 0 = none
- decoder_o_i  in  1  decoded bit from the Viterbi decoder
- encoder_i  out  1  bit to the encoder
- enable_encoder_i  out  1  encoder enable
- err_mask_o  out  2  XOR mask the channel applies to the same-cycle encoder word
- busy_o  out  1  high in any state but IDLE
- done_o  out  1  one-cycle pulse at end of frame
- bit_err_ct_o  out  16  decoded payload bits differing from sent bits
- chan_err_ct_o  out  16  channel bits flipped during the frame

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - All outputs and counters are 0.
  - Both LFSRs load their seeds.
  - The compare delay line is cleared.
  - Reset mid-frame behaves identically.
- States: IDLE, RUN, TAIL, DRAIN, DONE.
- IDLE:
  - On start_i=1, load the LFSRs with their seeds and clear both counters and the frame bit counter.
  - Go to RUN.
  - Counters otherwise hold their last values.
- RUN:
  - Exactly FRAME_LEN cycles, with enable_encoder_i=1 and encoder_i = payload LFSR bit 0.
  - The payload LFSR is 16-bit Fibonacci, taps 16,14,13,11, and advances every RUN cycle.
  - After the FRAME_LEN-th cycle, go to TAIL (or to DRAIN if TAIL_LEN=0).
- TAIL: TAIL_LEN cycles, with enable_encoder_i=1 and encoder_i=0; then go to DRAIN.
- enable_encoder_i is 0 in IDLE, DRAIN and DONE, and stays contiguous across RUN→TAIL.
- Error injection:
  - The error LFSR (same polynomial) advances every RUN/TAIL cycle.
  - If err_lfsr[3:0] < err_rate_i, err_mask_o = {err_lfsr[15], ~err_lfsr[15]}; otherwise 2'b00.
  - err_mask_o is 2'b00 outside RUN/TAIL.
  - chan_err_ct_o adds popcount(err_mask_o) each cycle.
- Compare delay line:
  - DEC_LAT stages of {valid, bit}.
  - Stage 0 captures {1, encoder_i} on RUN cycles and {0, x} otherwise.
  - When the final stage is valid and decoder_o_i ≠ its bit, bit_err_ct_o increments.
  - Exactly FRAME_LEN compares happen per frame; tail bits are never compared.
- DRAIN: wait until no valid tokens remain in the delay line, i.e. the cycle after the last compare; then go to DONE.
- DONE: done_o=1 for one cycle, then IDLE. busy_o falls in that IDLE cycle.
- Both counters saturate at 16'hFFFF.
- abort_i:
  - In any non-IDLE state, go to IDLE on the next edge.
  - Clear the delay-line valids; done_o is not pulsed.
  - Counters hold their partial values.
  - abort_i has priority over start_i and over the state-advance conditions.
- start_i outside IDLE is ignored.
- err_rate_i is sampled every cycle; changing it mid-frame is legal.

Optional Feature:
- Macro: VITERBI_BURST_ERR_EN
- When defined:
  - Every injection event forces err_mask_o on the following cycle to repeat the same mask, regardless of the LFSR.
  - If that following cycle is still in RUN/TAIL, this models back-to-back channel errors.
  - A repeated cycle does not itself trigger another repeat.
- When undefined: injection is independent per cycle as above.

Test Plan:
- Clean frame:
  - Setup: FRAME_LEN=16, TAIL_LEN=2, DEC_LAT=4; decoder modelled as a 4-cycle delay of encoder_i; err_rate_i=0; start_i at cycle 0.
  - Required: enable_encoder_i high cycles 1–18; done_o at cycle 21; bit_err_ct_o=0; chan_err_ct_o=0.
- Payload sequence: same setup; the first 4 encoder_i values must match the DATA_SEED LFSR (1,0,0,0 for 16'hACE1).
- Single decoded error: same setup, with the delay model inverting payload bit 5. Required: bit_err_ct_o=1 at done_o.
- Full injection:
  - Setup: err_rate_i=15, FRAME_LEN=256, TAIL_LEN=2.
  - Required: chan_err_ct_o = (number of cycles with err_lfsr[3:0]≠15) over the 258 cycles; err_mask_o is 0 outside RUN/TAIL; with VITERBI_BURST_ERR_EN, every injected cycle's mask repeats on the next cycle.
- Abort mid-RUN:
  - Stimulus: abort_i at the 8th RUN cycle.
  - Required: IDLE next cycle, enable_encoder_i=0, no done_o; a start_i issued 2 cycles later during the abort cycle is ignored, while a later start_i restarts from DATA_SEED.
- Reset mid-DRAIN: rst=0 for one cycle. Required: all outputs 0 next cycle, and no done_o afterwards.
